// File: rtl/lfsr_pkg.sv
// Shared encodings for the LFSR burst generator: mode bit, FSM states, default taps.
package lfsr_pkg;

    localparam logic LFSR_FIB = 1'b0;
    localparam logic LFSR_GAL = 1'b1;

    typedef logic [0:0] fsm_t;
    localparam fsm_t IDLE = 1'b0;
    localparam fsm_t RUN  = 1'b1;

    // x^16 + x^14 + x^13 + x^11 + 1, maximal length for the 16-bit default
    localparam logic [15:0] TAPS_DEFAULT = 16'hB400;

endpackage

// File: rtl/lfsr_step.sv
// One LFSR step in Fibonacci or Galois form, with the all-zero state replaced by 1.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    input  logic             mode,
    output logic [WIDTH-1:0] next,
    output logic             out_bit,
    output logic             zero_hit
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] raw;
    logic             fb;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        raw     = '0;
        out_bit = 1'b0;
        fb      = ^(state & taps);
        if (mode == LFSR_GAL) begin
            out_bit = state[WIDTH-1];
            raw     = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? taps : '0);
        end else begin
            out_bit = fb;
            raw     = {state[WIDTH-2:0], fb};
        end
        zero_hit = (raw == '0);
        next     = zero_hit ? ONE : raw;
    end

endmodule

// File: rtl/lfsr_burst_gen.sv
// Loadable Fibonacci/Galois LFSR bit generator with burst/free-run control FSM.
module lfsr_burst_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] TAPS_RST = WIDTH'(TAPS_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] taps,
    input  logic             mode,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             stop,
    input  logic             hold,
    output logic             q,
    output logic             q_valid,
    output logic [WIDTH-1:0] state,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] taps_q;
    logic             mode_q;
    fsm_t             fsm;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] next;
    logic             out_bit;
    logic             zero_hit;
    logic [WIDTH-1:0] seed_fix;
    logic             step_en;

    lfsr_step #(.WIDTH(WIDTH)) u_step (
        .state    (state),
        .taps     (taps_q),
        .mode     (mode_q),
        .next     (next),
        .out_bit  (out_bit),
        .zero_hit (zero_hit)
    );

    // A zero seed would lock the register, so it is quietly promoted to 1.
    assign seed_fix = (seed == '0) ? ONE : seed;
    assign step_en  = (fsm == RUN) && !load && !stop && !hold;
    assign busy     = (fsm == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ONE;
            seed_q  <= ONE;
            taps_q  <= TAPS_RST;
            mode_q  <= LFSR_FIB;
            fsm     <= IDLE;
            cnt     <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            lockup  <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            if (load) begin
                seed_q <= seed_fix;
                state  <= seed_fix;
                taps_q <= taps;
                mode_q <= mode;
                fsm    <= IDLE;
                lockup <= 1'b0;
            end else if (stop) begin
                fsm <= IDLE;
            end else if (fsm == IDLE) begin
                if (start) begin
                    fsm <= RUN;
                    cnt <= len;
                end
            end else if (step_en) begin
                state   <= next;
                q       <= out_bit;
                q_valid <= 1'b1;
                wrap    <= (next == seed_q);
                if (zero_hit) begin
                    lockup <= 1'b1;
                end
                // cnt == 0 means free-run: never decremented, never completes.
                if (cnt != '0) begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        done <= 1'b1;
                        fsm  <= IDLE;
                    end
                end
            end
        end
    end

endmodule
